// File: rtl/pixel_write_queue_if.sv
// rtl/pixel_write_queue_if.sv - plot stream in, framebuffer write port out
// master is the generator/memory side, slave is the queue.
interface pixel_write_queue_if;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic [14:0] fb_addr;
   logic [2:0]  fb_wdata;
   logic        fb_we;
   logic        fb_ready;

   modport master (
      output vga_x, vga_y, vga_colour, vga_plot, fb_ready,
      input  fb_addr, fb_wdata, fb_we
   );

   modport slave (
      input  vga_x, vga_y, vga_colour, vga_plot, fb_ready,
      output fb_addr, fb_wdata, fb_we
   );
endinterface

// File: rtl/pixel_write_queue.sv
// rtl/pixel_write_queue.sv - range-checks plot requests and queues framebuffer writes
// Head entry is held in registers so the write port is stable under backpressure.
module pixel_write_queue #(
   parameter int DEPTH = 8,
   parameter int H_RES = 160,
   parameter int V_RES = 120
) (
   input  logic                 clk,
   input  logic                 rst,
   pixel_write_queue_if.slave   bus,
   input  logic                 clear_stats,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic [15:0]          clip_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [17:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW-1:0] remaining;
   logic [14:0]   head_addr;
   logic [2:0]    head_wdata;
   logic [14:0]   addr;
   logic [17:0]   entry;
   logic [17:0]   next_head;
   logic          in_range;
   logic          push_req;
   logic          pop;
   logic          accept;

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign bus.fb_we    = !empty;
   assign bus.fb_addr  = head_addr;
   assign bus.fb_wdata = head_wdata;

   always_comb begin
      in_range = (32'(bus.vga_x) < H_RES) && (32'(bus.vga_y) < V_RES);
      addr     = 15'(32'(bus.vga_y) * H_RES + 32'(bus.vga_x));
      entry    = {addr, bus.vga_colour};
      pop      = !empty && bus.fb_ready;
      push_req = bus.vga_plot && in_range;
      accept   = push_req && (!full || pop);

      count_next = count;
      if (accept && !pop)
         count_next = count + CW'(1);
      else if (pop && !accept)
         count_next = count - CW'(1);

      // The head after this edge: next stored entry, else the incoming one, else hold.
      remaining = count - CW'(pop);
      next_head = {head_addr, head_wdata};
      if (remaining != '0)
         next_head = mem[rd_ptr + PW'(pop)];
      else if (accept)
         next_head = entry;
   end

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_addr  <= '0;
         head_wdata <= '0;
         overflow   <= 1'b0;
         clip_count <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count                   <= count_next;
         {head_addr, head_wdata} <= next_head;

         if (clear_stats) begin
            overflow   <= 1'b0;
            clip_count <= '0;
         end else begin
            if (push_req && !accept)
               overflow <= 1'b1;
            if (bus.vga_plot && !in_range && clip_count != 16'hFFFF)
               clip_count <= clip_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_pixel_write_queue.sv
// tb/tb_pixel_write_queue.sv - randomized and directed bench for pixel_write_queue
// Reference is a plain queue of {addr,colour} entries updated once per clock edge.
module tb_pixel_write_queue;
   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic        clear_stats;
   logic        full;
   logic        empty;
   logic        overflow;
   logic [15:0] clip_count;

   pixel_write_queue_if bus ();

   pixel_write_queue #(.DEPTH(DEPTH), .H_RES(160), .V_RES(120)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .clear_stats (clear_stats),
      .full        (full),
      .empty       (empty),
      .overflow    (overflow),
      .clip_count  (clip_count)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [17:0] m_q[$];
   logic [17:0] m_last;
   bit          m_ovf;
   int          m_clip;
   bit          model_on = 0;
   int          dut_writes = 0;
   int          max_addr = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_last = '0;
      m_ovf  = 0;
      m_clip = 0;
   endtask

   task automatic model_update();
      int  x;
      int  y;
      bit  inr;
      bit  pop;
      bit  req;
      bit  acc;
      x   = int'(bus.vga_x);
      y   = int'(bus.vga_y);
      inr = (x < 160) && (y < 120);
      pop = (m_q.size() > 0) && bus.fb_ready;
      req = bus.vga_plot && inr;
      acc = req && ((m_q.size() < DEPTH) || pop);
      if (pop)
         void'(m_q.pop_front());
      if (acc)
         m_q.push_back({15'(y * 160 + x), bus.vga_colour});
      if (clear_stats) begin
         m_ovf  = 0;
         m_clip = 0;
      end else begin
         if (req && !acc)
            m_ovf = 1;
         if (bus.vga_plot && !inr && m_clip < 65535)
            m_clip++;
      end
      if (m_q.size() > 0)
         m_last = m_q[0];
   endtask

   always @(negedge clk) begin
      if (model_on && !rst) begin
         logic [17:0] head;
         head = (m_q.size() > 0) ? m_q[0] : m_last;
         check("fb_we", 32'(bus.fb_we), 32'(m_q.size() != 0));
         check("empty", 32'(empty), 32'(m_q.size() == 0));
         check("full", 32'(full), 32'(m_q.size() == DEPTH));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("clip_count", 32'(clip_count), 32'(m_clip));
         check("fb_addr", 32'(bus.fb_addr), 32'(head[17:3]));
         check("fb_wdata", 32'(bus.fb_wdata), 32'(head[2:0]));
      end
   end

   task automatic tick();
      if (bus.fb_we && bus.fb_ready) begin
         dut_writes++;
         if (int'(bus.fb_addr) > max_addr)
            max_addr = int'(bus.fb_addr);
      end
      @(posedge clk);
      if (rst)
         model_reset();
      else
         model_update();
      #1;
   endtask

   task automatic drive(bit plot, int x, int y, int c, bit ready);
      bus.vga_plot   = plot;
      bus.vga_x      = 8'(x);
      bus.vga_y      = 7'(y);
      bus.vga_colour = 3'(c);
      bus.fb_ready   = ready;
   endtask

   initial begin
      int w0;
      rst         = 1'b1;
      clear_stats = 1'b0;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_fb_we", 32'(bus.fb_we), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_clip", 32'(clip_count), 32'd0);
      rst = 1'b0;
      model_reset();
      model_on = 1;
      tick();

      // single plot
      drive(1, 5, 3, 5, 1);
      tick();
      check("single_we", 32'(bus.fb_we), 32'd1);
      check("single_addr", 32'(bus.fb_addr), 32'd485);
      check("single_wdata", 32'(bus.fb_wdata), 32'd5);
      drive(0, 0, 0, 0, 1);
      tick();
      check("single_we_after", 32'(bus.fb_we), 32'd0);
      check("single_empty_after", 32'(empty), 32'd1);
      tick();

      // full-screen raster stream
      w0       = dut_writes;
      max_addr = 0;
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++) begin
            drive(1, x, y, x + y, 1);
            tick();
         end
      drive(0, 0, 0, 0, 1);
      repeat (2) tick();
      check("raster_writes", 32'(dut_writes - w0), 32'd19200);
      check("raster_max_addr", 32'(max_addr), 32'd19199);
      check("raster_overflow", 32'(overflow), 32'd0);
      check("raster_clip", 32'(clip_count), 32'd0);

      // backpressure overflow, then full with simultaneous pop
      w0 = dut_writes;
      for (int i = 0; i < 10; i++) begin
         drive(1, 10 + i, 2, i, 0);
         tick();
         if (i == 7)
            check("bp_full_at_8", 32'(full), 32'd1);
      end
      check("bp_overflow", 32'(overflow), 32'd1);
      check("bp_head_addr", 32'(bus.fb_addr), 32'd330);
      drive(0, 0, 0, 0, 0);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      check("bp_overflow_cleared", 32'(overflow), 32'd0);
      check("bp_full_kept", 32'(full), 32'd1);
      drive(1, 20, 20, 7, 1);
      tick();
      check("popfull_full", 32'(full), 32'd1);
      check("popfull_overflow", 32'(overflow), 32'd0);
      check("popfull_head", 32'(bus.fb_addr), 32'd331);
      drive(0, 0, 0, 0, 1);
      repeat (12) tick();
      check("bp_writes", 32'(dut_writes - w0), 32'd9);
      check("bp_empty", 32'(empty), 32'd1);

      // clipping
      w0 = dut_writes;
      drive(1, 160, 0, 1, 1);   tick();
      drive(1, 0, 120, 2, 1);   tick();
      drive(1, 255, 127, 3, 1); tick();
      drive(0, 10, 10, 4, 1);   tick();
      drive(0, 0, 0, 0, 1);     tick();
      check("clip_count3", 32'(clip_count), 32'd3);
      check("clip_writes", 32'(dut_writes - w0), 32'd0);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      check("clip_cleared", 32'(clip_count), 32'd0);

      // asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) begin
         drive(1, 30 + i, 40, i, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      check("prerst_we", 32'(bus.fb_we), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("async_rst_we", 32'(bus.fb_we), 32'd0);
      check("async_rst_empty", 32'(empty), 32'd1);
      check("async_rst_addr", 32'(bus.fb_addr), 32'd0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();
      w0 = dut_writes;
      drive(1, 159, 119, 2, 1);
      tick();
      check("postrst_we", 32'(bus.fb_we), 32'd1);
      check("postrst_addr", 32'(bus.fb_addr), 32'd19199);
      drive(0, 0, 0, 0, 1);
      repeat (2) tick();
      check("postrst_writes", 32'(dut_writes - w0), 32'd1);

      // randomized traffic with stalls and stat clears
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 200)),
               int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
               $urandom_range(0, 2) != 0);
         clear_stats = ($urandom_range(0, 99) == 0);
         tick();
      end
      clear_stats = 1'b0;
      drive(0, 0, 0, 0, 1);
      repeat (DEPTH + 2) tick();
      check("final_empty", 32'(empty), 32'd1);

      model_on = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Downstream stage of the pixel generators (fillscreen and circle drawers). It consumes their per-cycle plot stream (vga_x, vga_y, vga_colour, vga_plot) and writes it into the framebuffer memory.
- Per plot request, it range-checks the coordinates and computes the linear framebuffer address. Accepted requests go into a small FIFO.
- The FIFO drains through a valid/ready write port, so framebuffer stalls caused by scanout arbitration do not lose pixels unless the FIFO overflows.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.
- H_RES, 160, horizontal resolution; x is legal when x < H_RES.
- V_RES, 120, vertical resolution; y is legal when y < V_RES.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot request; sampled every cycle, no ready returned.
- clear_stats  in  1  synchronous clear of overflow and clip_count.
- fb_addr  out  15  framebuffer word address, = y*H_RES + x.
- fb_wdata  out  3  framebuffer write colour.
- fb_we  out  1  write valid; equals not-empty.
- fb_ready  in  1  memory accepts the write on a cycle where fb_we && fb_ready.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: an in-range request was dropped.
- clip_count  out  16  saturating count of out-of-range requests.

Behaviour:
- Reset: clk and rst only; reset is asynchronous, active-high. While rst=1:
  - FIFO pointers and count are 0; empty=1, full=0, fb_we=0.
  - fb_addr=0, fb_wdata=0, overflow=0, clip_count=0.
  - Asserting rst mid-operation discards all queued entries immediately. No write is issued on the cycle after reset releases.
- Definitions per cycle:
  - in_range = (vga_x < H_RES) && (vga_y < V_RES).
  - pop = fb_we && fb_ready.
  - push_req = vga_plot && in_range.
- Address arithmetic:
  - addr = vga_y*H_RES + vga_x, computed at full precision, then truncated to 15 bits.
  - For the defaults this is (y<<7)+(y<<5)+x; the maximum is 119*160+159 = 19199.
  - Each FIFO entry stores {addr[14:0], colour[2:0]}, 18 bits.
- Clipping:
  - vga_plot && !in_range: nothing is pushed, and clip_count increments, saturating at 16'hFFFF.
  - vga_plot=0 has no effect, whatever the coordinates are.
- Push acceptance:
  - push_req is accepted when count < DEPTH, or when count == DEPTH && pop in the same cycle (simultaneous pop frees a slot).
  - Otherwise the request is dropped and overflow <= 1. overflow stays set until clear_stats or rst.
- Count update:
  - accept && !pop: count+1.
  - pop && !accept: count-1.
  - accept && pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- Output:
  - fb_addr/fb_wdata always present the head entry; fb_we = !empty.
  - Outputs are stable while fb_we && !fb_ready, i.e. they hold until accepted.
  - When empty, fb_addr/fb_wdata hold their last value (0 after reset).
  - Latency: a push accepted at edge N into an empty FIFO gives fb_we=1 with that entry from edge N until popped.
  - Write order equals request order.
- Throughput: with fb_ready held at 1, one write per cycle is sustained indefinitely. Count never exceeds 1 when fed one plot per cycle.
- clear_stats:
  - clear_stats=1 zeroes overflow and clip_count at the edge.
  - If a clip or overflow event occurs on the same cycle, clear wins.
  - clear_stats does not affect FIFO contents.
- No X on any output after reset. Out-of-range coordinates never reach fb_addr.

Test Plan:
1. Single plot (x=5, y=3, colour=3'b101) for one cycle with fb_ready=1 → next cycle fb_we=1, fb_addr=485, fb_wdata=5; the following cycle fb_we=0, empty=1.
2. Full-screen stream: 19200 consecutive plots, raster order, fb_ready=1 → 19200 writes with addresses 0..19199 in order; overflow=0, clip_count=0, fb_addr never exceeds 19199.
3. Backpressure: fb_ready=0, 10 consecutive plots with DEPTH=8 → full=1 after 8 plots, overflow=1, fb_addr holds the first entry. Then fb_ready=1 → exactly 8 writes, matching the first 8 requests in order.
4. Full with simultaneous pop: with the FIFO at 8, plot on the same cycle as fb_ready=1 → request accepted, count stays 8, overflow stays 0.
5. Clipping: plots at (160,0), (0,120), (255,127), plus (10,10) with vga_plot=0 → no writes, clip_count=3. clear_stats pulse → clip_count=0.
6. Reset mid-operation: FIFO holding 5 entries with fb_ready=0, assert rst asynchronously between edges → fb_we drops immediately, empty=1. After release, a new plot (159,119) → single write with fb_addr=19199.
